// File: rtl/note_sequencer_if.sv
// Song playback bundle: control levels/pulses, register-file read port
// and tone-generator outputs.
interface note_sequencer_if;
  logic        start;
  logic        stop;
  logic        play_en;
  logic        loop;
  logic [15:0] rd_addr;
  logic [11:0] rd_data;
  logic [3:0]  note;
  logic [2:0]  octave;
  logic        note_on;
  logic        note_start;
  logic        busy;
  logic        done;

  modport master (
    output start, stop, play_en, loop, rd_data,
    input  rd_addr, note, octave, note_on,
    input  note_start, busy, done
  );

  modport slave (
    input  start, stop, play_en, loop, rd_data,
    output rd_addr, note, octave, note_on,
    output note_start, busy, done
  );
endinterface

// File: rtl/note_sequencer.sv
// Walks the note register file and plays each entry for its duration,
// gating the tone generator with an articulation gap at note end.
module note_sequencer #(
  parameter int TICK_DIV  = 12_500_000,
  parameter int GAP_TICKS = 1_250_000,
  parameter int SONG_LEN  = 150
) (
  input logic            clk,
  input logic            rst,
  note_sequencer_if.slave bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] GAP_START = TW'(TICK_DIV - GAP_TICKS);
  localparam logic [15:0]   ADDR_LAST = 16'(SONG_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_FETCH, S_PLAY, S_DONE
  } state_t;

  state_t        r_state, w_state_nx;
  logic [15:0]   r_addr, w_addr_nx;
  logic [3:0]    r_note, w_note_nx;
  logic [2:0]    r_oct, w_oct_nx;
  logic [4:0]    r_unit, w_unit_nx;
  logic [TW-1:0] r_tick, w_tick_nx;
  logic          r_nstart, w_nstart_nx;
  logic          w_adv;
  logic          w_wrap;
  logic [4:0]    w_dur;

  assign w_wrap = (r_tick == TICK_LAST);
  assign w_dur  = bus.rd_data[4:0];

  always_comb begin
    w_state_nx  = r_state;
    w_addr_nx   = r_addr;
    w_note_nx   = r_note;
    w_oct_nx    = r_oct;
    w_unit_nx   = r_unit;
    w_tick_nx   = r_tick;
    w_nstart_nx = 1'b0;
    w_adv       = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_addr_nx  = '0;
          w_state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        w_note_nx = bus.rd_data[11:8];
        w_oct_nx  = bus.rd_data[7:5];
        if (w_dur == 5'd0) begin
          w_adv = 1'b1;
        end else begin
          w_unit_nx   = w_dur;
          w_tick_nx   = '0;
          w_nstart_nx = 1'b1;
          w_state_nx  = S_PLAY;
        end
      end
      S_PLAY: begin
        if (bus.play_en) begin
          if (w_wrap) begin
            w_tick_nx = '0;
            w_unit_nx = r_unit - 5'd1;
            w_adv     = (r_unit == 5'd1);
          end else begin
            w_tick_nx = r_tick + TW'(1);
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    // Note end and skipped entries share the same advance rule
    if (w_adv) begin
      if (r_addr != ADDR_LAST) begin
        w_addr_nx  = r_addr + 16'd1;
        w_state_nx = S_FETCH;
      end else if (bus.loop) begin
        w_addr_nx  = '0;
        w_state_nx = S_FETCH;
      end else begin
        w_state_nx = S_DONE;
      end
    end
    if (bus.stop) begin
      w_state_nx  = S_IDLE;
      w_addr_nx   = '0;
      w_note_nx   = '0;
      w_oct_nx    = '0;
      w_nstart_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_note   <= '0;
      r_oct    <= '0;
      r_unit   <= '0;
      r_tick   <= '0;
      r_nstart <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_addr   <= w_addr_nx;
      r_note   <= w_note_nx;
      r_oct    <= w_oct_nx;
      r_unit   <= w_unit_nx;
      r_tick   <= w_tick_nx;
      r_nstart <= w_nstart_nx;
    end
  end

  assign bus.rd_addr    = r_addr;
  assign bus.note       = r_note;
  assign bus.octave     = r_oct;
  assign bus.note_start = r_nstart;
  assign bus.busy       = (r_state == S_FETCH) | (r_state == S_PLAY);
  assign bus.done       = (r_state == S_DONE);
  assign bus.note_on    = (r_state == S_PLAY) & bus.play_en
                        & (r_note != 4'd0)
                        & ~((r_unit == 5'd1) & (r_tick >= GAP_START));

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: TICK_DIV=4, GAP_TICKS=1,
// SONG_LEN=3 with a behavioural register file.
module tb_note_sequencer;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  logic [11:0] mem [0:2];

  logic [15:0] c_addr [0:63];
  logic [3:0]  c_note [0:63];
  logic [2:0]  c_oct  [0:63];
  logic        c_on   [0:63];
  logic        c_ns   [0:63];
  logic        c_busy [0:63];
  logic        c_done [0:63];

  note_sequencer_if bus ();

  note_sequencer #(
    .TICK_DIV (4),
    .GAP_TICKS(1),
    .SONG_LEN (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.rd_data = (bus.rd_addr < 16'd3)
                     ? mem[bus.rd_addr[1:0]] : 12'h000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entry encoding: note[11:8] octave[7:5] dur[4:0]
  function automatic logic [11:0] ent(
    input int n, input int o, input int d);
    return {4'(n), 3'(o), 5'(d)};
  endfunction

  // Edge 0 samples start; cycle c is captured mid-cycle after edge c-1.
  task automatic run_song(input int n, input bit lp,
                          input int pe_a, input int pe_b,
                          input int ss);
    @(negedge clk);
    bus.stop  = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.stop    = 1'b0;
    bus.start   = 1'b1;
    bus.loop    = lp;
    bus.play_en = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      bus.start   = (c == ss);
      bus.stop    = (c == ss);
      bus.play_en = !(c >= pe_a && c <= pe_b);
      #1;
      c_addr[c] = bus.rd_addr;
      c_note[c] = bus.note;
      c_oct[c]  = bus.octave;
      c_on[c]   = bus.note_on;
      c_ns[c]   = bus.note_start;
      c_busy[c] = bus.busy;
      c_done[c] = bus.done;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic test_reset;
    n_chk++;
    if ({bus.rd_addr, bus.note, bus.octave} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_fields got %0h/%0h/%0h want 0",
               bus.rd_addr, bus.note, bus.octave);
    end
    n_chk++;
    if ({bus.note_on, bus.note_start, bus.busy, bus.done}
        !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got %b%b%b%b want 0000",
               bus.note_on, bus.note_start, bus.busy, bus.done);
    end
  endtask

  task automatic test_song;
    logic e_on, e_busy, e_done;
    logic [15:0] e_addr;
    mem[0] = ent(6, 2, 2);
    mem[1] = ent(0, 2, 1);
    mem[2] = ent(9, 1, 1);
    run_song(22, 1'b0, 99, 99, 99);
    for (int c = 1; c <= 22; c++) begin
      e_on   = (c >= 2 && c <= 8) || (c >= 16 && c <= 18);
      e_busy = (c <= 19);
      e_done = (c >= 20);
      e_addr = (c < 10) ? 16'd0 : (c < 15) ? 16'd1 : 16'd2;
      n_chk++;
      if (c_on[c] !== e_on) begin
        n_fail++;
        $display("FAIL song_note_on c%0d got %b want %b",
                 c, c_on[c], e_on);
      end
      n_chk++;
      if (c_addr[c] !== e_addr) begin
        n_fail++;
        $display("FAIL song_addr c%0d got %0d want %0d",
                 c, c_addr[c], e_addr);
      end
      n_chk++;
      if ({c_busy[c], c_done[c]} !== {e_busy, e_done}) begin
        n_fail++;
        $display("FAIL song_busy_done c%0d got %b%b want %b%b",
                 c, c_busy[c], c_done[c], e_busy, e_done);
      end
      if (c != 11) begin
        n_chk++;
        if (c_ns[c] !== (c == 2 || c == 16)) begin
          n_fail++;
          $display("FAIL song_note_start c%0d got %b", c, c_ns[c]);
        end
      end
    end
    n_chk++;
    if ({c_note[2], c_oct[2]} !== {4'd6, 3'd2}) begin
      n_fail++;
      $display("FAIL song_decode got %0d/%0d want 6/2",
               c_note[2], c_oct[2]);
    end
    n_chk++;
    if ({c_note[22], c_oct[22]} !== {4'd9, 3'd1}) begin
      n_fail++;
      $display("FAIL done_hold got %0d/%0d want 9/1",
               c_note[22], c_oct[22]);
    end
  endtask

  task automatic test_skip;
    logic [15:0] e_addr;
    logic e_on;
    mem[0] = ent(6, 2, 2);
    mem[1] = ent(0, 2, 0);
    mem[2] = ent(9, 1, 1);
    run_song(18, 1'b0, 99, 99, 99);
    for (int c = 1; c <= 18; c++) begin
      e_addr = (c < 10) ? 16'd0 : (c == 10) ? 16'd1 : 16'd2;
      e_on   = (c >= 2 && c <= 8) || (c >= 12 && c <= 14);
      n_chk++;
      if (c_addr[c] !== e_addr) begin
        n_fail++;
        $display("FAIL skip_addr c%0d got %0d want %0d",
                 c, c_addr[c], e_addr);
      end
      n_chk++;
      if (c_ns[c] !== (c == 2 || c == 12)) begin
        n_fail++;
        $display("FAIL skip_note_start c%0d got %b", c, c_ns[c]);
      end
      n_chk++;
      if (c_on[c] !== e_on) begin
        n_fail++;
        $display("FAIL skip_note_on c%0d got %b want %b",
                 c, c_on[c], e_on);
      end
      n_chk++;
      if (c_done[c] !== (c >= 16)) begin
        n_fail++;
        $display("FAIL skip_done c%0d got %b", c, c_done[c]);
      end
    end
  endtask

  task automatic test_loop;
    mem[0] = ent(6, 2, 2);
    mem[1] = ent(0, 2, 1);
    mem[2] = ent(9, 1, 1);
    run_song(42, 1'b1, 99, 99, 99);
    n_chk++;
    if ({c_addr[19], c_addr[20], c_addr[29]}
        !== {16'd2, 16'd0, 16'd1}) begin
      n_fail++;
      $display("FAIL loop_addr got %0d,%0d,%0d want 2,0,1",
               c_addr[19], c_addr[20], c_addr[29]);
    end
    n_chk++;
    if ({c_ns[21], c_on[21]} !== 2'b11) begin
      n_fail++;
      $display("FAIL loop_restart got %b%b want 11",
               c_ns[21], c_on[21]);
    end
    for (int c = 1; c <= 42; c++) begin
      n_chk++;
      if ({c_busy[c], c_done[c]} !== 2'b10) begin
        n_fail++;
        $display("FAIL loop_busy_done c%0d got %b%b want 10",
                 c, c_busy[c], c_done[c]);
      end
    end
  endtask

  task automatic test_pause;
    logic e_on;
    mem[0] = ent(6, 2, 2);
    mem[1] = ent(0, 2, 1);
    mem[2] = ent(9, 1, 1);
    run_song(16, 1'b0, 4, 8, 99);
    for (int c = 2; c <= 16; c++) begin
      e_on = (c == 2 || c == 3) || (c >= 9 && c <= 13);
      n_chk++;
      if (c_on[c] !== e_on) begin
        n_fail++;
        $display("FAIL pause_note_on c%0d got %b want %b",
                 c, c_on[c], e_on);
      end
    end
    n_chk++;
    if ({c_addr[14], c_addr[15]} !== {16'd0, 16'd1}) begin
      n_fail++;
      $display("FAIL pause_fetch got %0d,%0d want 0,1",
               c_addr[14], c_addr[15]);
    end
  endtask

  task automatic test_stop_start;
    mem[0] = ent(6, 2, 2);
    mem[1] = ent(0, 2, 1);
    mem[2] = ent(9, 1, 1);
    run_song(8, 1'b0, 99, 99, 5);
    n_chk++;
    if ({c_busy[5], c_on[5]} !== 2'b11) begin
      n_fail++;
      $display("FAIL stop_before got %b%b want 11",
               c_busy[5], c_on[5]);
    end
    for (int c = 6; c <= 8; c++) begin
      n_chk++;
      if ({c_busy[c], c_on[c], c_done[c], c_addr[c],
           c_note[c], c_oct[c]} !== 26'd0) begin
        n_fail++;
        $display("FAIL stop_idle c%0d got b%b on%b d%b a%0d n%0d",
                 c, c_busy[c], c_on[c], c_done[c],
                 c_addr[c], c_note[c]);
      end
    end
  endtask

  task automatic test_async_reset;
    mem[0] = ent(6, 2, 2);
    run_song(5, 1'b0, 99, 99, 99);
    @(negedge clk);
    n_chk++;
    if ({bus.busy, bus.note_on} !== 2'b11) begin
      n_fail++;
      $display("FAIL arst_pre got %b%b want 11",
               bus.busy, bus.note_on);
    end
    #1 rst = 1'b1;
    #1;
    test_reset;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.play_en = 1'b1;
    bus.loop    = 1'b0;
    mem[0] = 12'h000;
    mem[1] = 12'h000;
    mem[2] = 12'h000;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    test_song;
    test_skip;
    test_loop;
    test_pause;
    test_stop_start;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
